mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates two requesters for the single-port 16-bit x 4096 on-chip RAM: the CPU (read/write) and the video fetch unit (read-only).
- Drives the RAM's en/wr_en/addr/data_in and routes its registered data_out back to the owner of each read.
- CPU has fixed priority. A wait-limit counter keeps the video port from starving.

Parameters:
- DATA_W, 16, data word width (matches RAM_WIDTH).
- ADDR_W, 12, word address width (matches RAM_ADDR_BITS).
- VID_MAX_WAIT, 4, number of consecutive denied video-request cycles after which video takes priority; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (registered, reads only)
- cpu_rdata  out  DATA_W  CPU read data
- vid_req  in  1  video read request, held until granted
- vid_addr  in  ADDR_W  video word address
- vid_gnt  out  1  video access accepted this cycle (combinational)
- vid_rvalid  out  1  vid_rdata valid (registered)
- vid_rdata  out  DATA_W  video read data
- ram_en  out  1  to RAM en
- ram_wr_en  out  1  to RAM wr_en
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM data_in
- ram_dout  in  DATA_W  from RAM data_out; valid one cycle after an enabled access

Behaviour:
- Grant decision (combinational, each cycle):
  - vid_gnt = vid_req & (~cpu_req | starve), where starve = (wait_cnt >= VID_MAX_WAIT).
  - cpu_gnt = cpu_req & ~vid_gnt.
  - At most one grant per cycle.
- RAM drive:
  - ram_en = cpu_gnt | vid_gnt.
  - ram_wr_en = cpu_gnt & cpu_we.
  - ram_addr = vid_addr when vid_gnt, else cpu_addr.
  - ram_din = cpu_wdata.
  - With no grant: ram_en = 0 and ram_wr_en = 0; ram_addr/ram_din are don't-care but must be stable (pass cpu_addr/cpu_wdata).
- Handshake: the requester holds req/addr/we/wdata stable until gnt is sampled high. The transfer occurs in the gnt cycle. The requester may present a new request in the next cycle, so back-to-back grants are allowed (one access per clock).
- Read return (latency 1):
  - State: a registered tag {rd_pending, rd_owner} captured at the grant edge.
  - rd_pending <= (cpu_gnt & ~cpu_we) | vid_gnt.
  - rd_owner <= vid_gnt.
  - cpu_rvalid = rd_pending & ~rd_owner; vid_rvalid = rd_pending & rd_owner.
  - cpu_rdata and vid_rdata both = ram_dout, qualified only by their rvalid.
  - Writes produce no rvalid.
- Starvation counter wait_cnt (4-bit, saturating at 15):
  - vid_req & ~vid_gnt: increment.
  - vid_gnt: clear to 0.
  - ~vid_req: clear to 0.
  - When starve is asserted, video wins even against cpu_req. The counter clears on that grant, so the CPU regains priority the next cycle.
- Reset (async, active-high): rd_pending = 0, rd_owner = 0, wait_cnt = 0.
  - Reset values: cpu_rvalid = 0, vid_rvalid = 0. cpu_rdata and vid_rdata follow ram_dout and are don't-care.
  - While reset is high, grants are forced to 0, so ram_en = 0 and ram_wr_en = 0.
  - A read granted in the cycle before reset asserts produces no rvalid after reset deasserts.
- Boundaries:
  - Simultaneous requests below the limit: CPU wins.
  - CPU write and video read in the same cycle: only one is granted; the other waits.
  - Addresses 0 and 'hFFF pass through unmodified; there is no wrap logic in this block.

Test Plan:
- After reset: cpu_req = 1, cpu_we = 1, cpu_addr = 'h010, cpu_wdata = 'hBEEF for 1 cycle -> cpu_gnt = 1, ram_wr_en = 1, no rvalid. Then a CPU read of 'h010 -> cpu_rvalid high exactly 1 cycle after gnt with cpu_rdata = 'hBEEF.
- Video only: vid_req = 1 for addresses 'h100..'h103 on consecutive cycles -> vid_gnt = 1 every cycle. vid_rvalid follows each grant by 1 cycle with the matching data in order; cpu_rvalid stays 0.
- Contention, VID_MAX_WAIT = 4: cpu_req and vid_req held continuously -> CPU granted 4 cycles, video granted on the 5th, then the CPU again; pattern repeats with period 5. Check vid_rvalid and cpu_rvalid tags never swap.
- Interleaved reads: CPU read 'h020 (preloaded 'h1111), then video read 'h021 (preloaded 'h2222) on the next cycle -> cpu_rvalid with 'h1111, then vid_rvalid with 'h2222 on consecutive cycles.
- Reset mid-operation: CPU read granted, reset asserted asynchronously before the next edge -> cpu_rvalid = 0 immediately and stays 0 after release; wait_cnt restarts from 0 (verify with the 4:1 pattern restarting).
- Write starvation check: cpu_req with cpu_we = 1 held continuously plus vid_req -> video still granted on every 5th cycle, and no write is issued in those cycles (ram_wr_en = 0 when vid_gnt = 1).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port on-chip RAM: CPU (read/write, fixed priority)
// and video fetch (read-only) with a wait-limit counter that keeps video from starving.
module mem_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned VID_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,

    output logic              ram_en,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(VID_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

    logic [WAIT_W-1:0] wait_cnt;
    logic              starve;
    logic              rd_pending;
    logic              rd_owner;

    // Grant decision: CPU wins unless video has waited long enough; nothing is granted in reset.
    always_comb begin
        starve  = (wait_cnt >= WAIT_LIMIT);
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            vid_gnt = vid_req & (~cpu_req | starve);
            cpu_gnt = cpu_req & ~vid_gnt;
        end
    end

    // RAM drive: address/data default to the CPU side so they stay stable when idle.
    always_comb begin
        ram_en    = cpu_gnt | vid_gnt;
        ram_wr_en = cpu_gnt & cpu_we;
        ram_addr  = vid_gnt ? vid_addr : cpu_addr;
        ram_din   = cpu_wdata;
    end

    // Read-return tag, captured on the grant edge; the RAM answers one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= (cpu_gnt & ~cpu_we) | vid_gnt;
            rd_owner   <= vid_gnt;
        end
    end

    // Consecutive denied video-request cycles, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!vid_req || vid_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign cpu_rvalid = rd_pending & ~rd_owner;
    assign vid_rvalid = rd_pending & rd_owner;
    assign cpu_rdata  = ram_dout;
    assign vid_rdata  = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, reference arbiter model with a read-return
// scoreboard, a table of per-cycle vectors and a hand-written reset-mid-operation sequence.
module tb_mem_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned MAXW   = 4;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              vid_req, vid_gnt, vid_rvalid;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              ram_en, ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VID_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered output.
    logic [DATA_W-1:0] mem [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: expected grants, RAM contents and the queue of pending read returns.
    typedef struct { logic vid; logic [DATA_W-1:0] data; } rd_t;
    rd_t               rdq [$];
    rd_t               r;
    logic [DATA_W-1:0] ref_mem [4096];
    int unsigned       m_wait = 0;
    logic              ev, ec;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_cpu_gnt", 32'(cpu_gnt), 0);
            check("rst_vid_gnt", 32'(vid_gnt), 0);
            check("rst_ram_en", 32'(ram_en), 0);
            check("rst_ram_wr_en", 32'(ram_wr_en), 0);
            check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
            check("rst_vid_rvalid", 32'(vid_rvalid), 0);
            rdq.delete();
            m_wait = 0;
        end else begin
            if (rdq.size() > 0) begin
                r = rdq.pop_front();
                check("cpu_rvalid", 32'(cpu_rvalid), 32'(!r.vid));
                check("vid_rvalid", 32'(vid_rvalid), 32'(r.vid));
                if (r.vid) check("vid_rdata", 32'(vid_rdata), 32'(r.data));
                else       check("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
            end else begin
                check("cpu_rvalid_idle", 32'(cpu_rvalid), 0);
                check("vid_rvalid_idle", 32'(vid_rvalid), 0);
            end
            ev = vid_req && (!cpu_req || m_wait >= MAXW);
            ec = cpu_req && !ev;
            check("m_cpu_gnt", 32'(cpu_gnt), 32'(ec));
            check("m_vid_gnt", 32'(vid_gnt), 32'(ev));
            check("m_ram_en", 32'(ram_en), 32'(ec || ev));
            check("m_ram_wr_en", 32'(ram_wr_en), 32'(ec && cpu_we));
            check("m_ram_addr", 32'(ram_addr), 32'(ev ? vid_addr : cpu_addr));
            check("m_ram_din", 32'(ram_din), 32'(cpu_wdata));
            if (ev)                 rdq.push_back('{1'b1, ref_mem[vid_addr]});
            else if (ec && !cpu_we) rdq.push_back('{1'b0, ref_mem[cpu_addr]});
            else if (ec)            ref_mem[cpu_addr] = cpu_wdata;
            if (!vid_req || ev)  m_wait = 0;
            else if (m_wait < 15) m_wait++;
        end
    end

    typedef struct {
        logic              c_req, c_we;
        logic [ADDR_W-1:0] c_addr;
        logic [DATA_W-1:0] c_wdata;
        logic              v_req;
        logic [ADDR_W-1:0] v_addr;
        logic              e_cgnt, e_vgnt;
    } vec_t;
    vec_t vecs [$];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                                input logic [DATA_W-1:0] cd, input logic vr,
                                input logic [ADDR_W-1:0] va, input logic ecg, input logic evg);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.v_req = vr; v.v_addr = va; v.e_cgnt = ecg; v.e_vgnt = evg;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wdata;
        vid_req = v.v_req; vid_addr = v.v_addr;
    endtask

    initial begin
        reset = 1'b1;
        apply(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));

        vecs.push_back(mk(1, 1, 12'h010, 16'hBEEF, 0, 12'h000, 1, 0));
        vecs.push_back(mk(1, 0, 12'h010, 16'hBEEF, 0, 12'h000, 1, 0));
        vecs.push_back(mk(0, 0, 12'h010, 16'hBEEF, 0, 12'h000, 0, 0));
        vecs.push_back(mk(1, 1, 12'h020, 16'h1111, 0, 12'h000, 1, 0));
        vecs.push_back(mk(1, 1, 12'h021, 16'h2222, 0, 12'h000, 1, 0));
        vecs.push_back(mk(1, 1, 12'h030, 16'h3030, 0, 12'h000, 1, 0));
        vecs.push_back(mk(1, 1, 12'hFFF, 16'h0FFF, 0, 12'h000, 1, 0));
        vecs.push_back(mk(1, 1, 12'h000, 16'h5A5A, 0, 12'h000, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1, 12'h100 + 12'(i), 16'hA000 + 16'(i), 0, 12'h000, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 1, 12'h100 + 12'(i), 0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(1, 0, 12'h020, 16'h0000, 0, 12'h000, 1, 0));
        vecs.push_back(mk(0, 0, 12'h020, 16'h0000, 1, 12'h021, 0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));
        // Continuous contention, reads then writes: 4 CPU grants then 1 video grant.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 0, 12'h030, 16'h0000, 1, 12'h020, (i % 5) != 4, (i % 5) == 4));
        vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 1, 12'h050, 16'h5555, 1, 12'h010, (i % 5) != 4, (i % 5) == 4));
        vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(1, 0, 12'hFFF, 16'h0000, 0, 12'h000, 1, 0));
        vecs.push_back(mk(0, 0, 12'hFFF, 16'h0000, 1, 12'h000, 0, 1));
        vecs.push_back(mk(1, 1, 12'h0FF, 16'h00FF, 1, 12'h0FF, 1, 0));
        vecs.push_back(mk(0, 0, 12'h0FF, 16'h00FF, 1, 12'h0FF, 0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        foreach (vecs[i]) begin
            @(posedge clk);
            #1 apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_cgnt));
            check($sformatf("vec%0d_vid_gnt", i), 32'(vid_gnt), 32'(vecs[i].e_vgnt));
            if (vecs[i].e_vgnt) check($sformatf("vec%0d_no_wr", i), 32'(ram_wr_en), 0);
        end

        // Build up a partial wait count, then reset just after a granted CPU read.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 apply(mk(1, 0, 12'h010, 16'h0000, 1, 12'h030, 1, 0));
            @(negedge clk);
            check("pre_rst_cpu_gnt", 32'(cpu_gnt), 1);
        end
        @(posedge clk);
        #1 check("pre_rst_rvalid", 32'(cpu_rvalid), 1);
        #1 reset = 1'b1;
        #1 check("async_rst_rvalid", 32'(cpu_rvalid), 0);
        check("async_rst_ram_en", 32'(ram_en), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_cpu_gnt", 32'(cpu_gnt), 32'((i % 5) != 4));
            check("post_rst_vid_gnt", 32'(vid_gnt), 32'((i % 5) == 4));
        end
        @(posedge clk);
        #1 apply(mk(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0));
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(rdq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
